// File: rtl/msg_rx_parser_pkg.sv
// Master command message definitions shared by the slave RX/TX paths.
// Marker/flag byte values, parser state encoding and error causes.
package msg_rx_parser_pkg;

  localparam logic [7:0] MARKER_MASTER            = 8'hC5;
  localparam logic [7:0] FLAG_TIME_MARK           = 8'h54;
  localparam logic [7:0] FLAG_STATUS_REQUEST      = 8'h53;
  localparam logic [7:0] FLAG_DATA_PACKET_REQUEST = 8'h44;

  localparam int MSG_LEN_DEFAULT = 4;

  localparam logic [1:0] ERR_FLAG = 2'd1;
  localparam logic [1:0] ERR_PAD  = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FLAG,
    ST_PAD,
    ST_DONE
  } rx_state_t;

  function automatic logic is_flag(input logic [7:0] b);
    return (b == FLAG_TIME_MARK) ||
           (b == FLAG_STATUS_REQUEST) ||
           (b == FLAG_DATA_PACKET_REQUEST);
  endfunction

endpackage

// File: rtl/msg_rx_parser_tmo.sv
// Loadable inactivity counter; expire pulses in the cycle
// whose edge would bring the count to LIMIT-1.
module rx_timeout_cntr #(
  parameter int LIMIT = 1024,
  localparam int W = $clog2(LIMIT) + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && cnt != W'(LIMIT - 1)) begin
      cnt <= cnt + W'(1);
    end
  end

  assign expire = en && !clr && !load &&
                  (cnt == W'(LIMIT - 2));

endmodule

// File: rtl/msg_rx_parser.sv
// Slave-side parser for master TM/SR/DPR command messages.
// Frames marker, flag and pad bytes; pulses per type or error.
module msg_rx_parser
  import msg_rx_parser_pkg::*;
#(
  parameter int MSG_LEN     = MSG_LEN_DEFAULT,
  parameter int TIMEOUT_CYC = 1024,
  parameter int STRICT_PAD  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] d,
  input  logic       d_rdy,
  output logic       tm_rcvd,
  output logic       sr_rcvd,
  output logic       dpr_rcvd,
  output logic       msg_err,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam int BCW = $clog2(MSG_LEN) + 1;
  localparam int TW  = $clog2(TIMEOUT_CYC) + 1;

  rx_state_t      state;
  logic [BCW-1:0] bcnt;
  logic [7:0]     flag_q;
  logic           tmo_expire;

  rx_timeout_cntr #(
    .LIMIT(TIMEOUT_CYC)
  ) u_tmo (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (busy),
    .clr      (d_rdy),
    .load     (1'b0),
    .load_val ({TW{1'b0}}),
    .expire   (tmo_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      bcnt     <= '0;
      flag_q   <= '0;
      err_code <= '0;
      tm_rcvd  <= 1'b0;
      sr_rcvd  <= 1'b0;
      dpr_rcvd <= 1'b0;
      msg_err  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      tm_rcvd  <= 1'b0;
      sr_rcvd  <= 1'b0;
      dpr_rcvd <= 1'b0;
      msg_err  <= 1'b0;
      unique case (state)
        // DONE accepts a new marker so back-to-back frames survive
        ST_IDLE, ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          if (d_rdy && d == MARKER_MASTER) begin
            state <= ST_FLAG;
            busy  <= 1'b1;
          end
        end
        ST_FLAG: begin
          if (d_rdy && is_flag(d)) begin
            flag_q <= d;
            if (MSG_LEN == 2) begin
              state    <= ST_DONE;
              busy     <= 1'b0;
              tm_rcvd  <= (d == FLAG_TIME_MARK);
              sr_rcvd  <= (d == FLAG_STATUS_REQUEST);
              dpr_rcvd <= (d == FLAG_DATA_PACKET_REQUEST);
            end else begin
              bcnt  <= BCW'(MSG_LEN - 2);
              state <= ST_PAD;
            end
          end else if (d_rdy || tmo_expire) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            msg_err  <= 1'b1;
            err_code <= d_rdy ? ERR_FLAG : ERR_TMO;
          end
        end
        ST_PAD: begin
          if (d_rdy && STRICT_PAD != 0 && d != 8'h00) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            msg_err  <= 1'b1;
            err_code <= ERR_PAD;
          end else if (d_rdy) begin
            bcnt <= bcnt - BCW'(1);
            if (bcnt == BCW'(1)) begin
              state    <= ST_DONE;
              busy     <= 1'b0;
              tm_rcvd  <= (flag_q == FLAG_TIME_MARK);
              sr_rcvd  <= (flag_q == FLAG_STATUS_REQUEST);
              dpr_rcvd <= (flag_q == FLAG_DATA_PACKET_REQUEST);
            end
          end else if (tmo_expire) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            msg_err  <= 1'b1;
            err_code <= ERR_TMO;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/msg_rx_parser.md
Name: msg_rx_parser

Overview:
- Slave-side receiver for the master command messages: Time Mark (TM), Status Request (SR) and Data Packet Request (DPR).
- Consumes the byte stream from the line decoder as a byte plus a one-cycle strobe.
- Checks framing: master marker byte, then flag byte, then MSG_LEN-2 pad bytes.
- Emits one-cycle "message received" pulses per type, or an error pulse with a cause code. Sits between the line decoder and the slave response controller.

Parameters:
- MSG_LEN, 4, total message length in bytes: marker + flag + pad bytes. Legal range 2..16.
- TIMEOUT_CYC, 1024, max clk cycles allowed between consecutive byte strobes inside a message.
- STRICT_PAD, 1, 1 = every pad byte must equal 8'h00; 0 = pad bytes are not checked.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- d  in  8  received byte from the line decoder.
- d_rdy  in  1  one-cycle strobe; d is valid this cycle.
- tm_rcvd  out  1  one-cycle pulse: valid TM message received.
- sr_rcvd  out  1  one-cycle pulse: valid SR message received.
- dpr_rcvd  out  1  one-cycle pulse: valid DPR message received.
- msg_err  out  1  one-cycle pulse: message aborted.
- err_code  out  2  cause of the last msg_err, held until the next msg_err. 1 = bad flag, 2 = bad pad, 3 = timeout.
- busy  out  1  high while a message is partially received (state is not IDLE).

Behaviour:
- Reset (rst_n low, async): state=IDLE, byte counter=0, timeout counter=0, flag register=0, err_code=0. All pulse outputs and busy are 0.
- Marker and flag constants come from the shared message definitions: MARKER_MASTER, FLAG_TIME_MARK, FLAG_STATUS_REQUEST, FLAG_DATA_PACKET_REQUEST.
- FSM states: IDLE, FLAG, PAD, DONE.
- IDLE:
  - On d_rdy with d==MARKER_MASTER, go to FLAG.
  - Any other byte is discarded silently; no error is raised.
- FLAG:
  - On d_rdy with d equal to one of the three flags, latch the flag.
  - If MSG_LEN==2, go to DONE; otherwise load byte counter = MSG_LEN-2 and go to PAD.
  - Any other value: msg_err=1, err_code=1, return to IDLE. A marker value here is also an error and does not restart framing.
- PAD:
  - Each d_rdy decrements the byte counter.
  - If STRICT_PAD and d!=0: msg_err, err_code=2, return to IDLE.
  - When the last pad byte is accepted (counter reaches 0), go to DONE.
- DONE: lasts exactly one cycle.
  - Assert exactly one of tm_rcvd, sr_rcvd or dpr_rcvd, selected by the latched flag.
  - Return to IDLE.
  - A d_rdy arriving during DONE is handled exactly as if the state were IDLE, so back-to-back messages are not lost.
- Latency: the rcvd pulse is high in the cycle after the clk edge that accepts the final byte. msg_err has the same one-cycle latency after the offending byte.
- Timeout:
  - The counter increments each cycle in FLAG or PAD and clears on every d_rdy.
  - When it reaches TIMEOUT_CYC-1 without a d_rdy: msg_err, err_code=3, return to IDLE.
  - If d_rdy coincides with the expiry cycle, the byte wins and no timeout is raised.
  - Counter width is clog2(TIMEOUT_CYC)+1.
- busy = (state==FLAG or state==PAD).
- At most one of tm_rcvd, sr_rcvd, dpr_rcvd, msg_err is high in any cycle.
- rst_n asserted mid-message: the partial message is discarded and no pulse is issued.

Decomposition:
- Shared header (existing message definitions): MARKER_MASTER and the three FLAG_* constants.
- New entries in the same header: state encodings, error-code localparams ERR_FLAG=1, ERR_PAD=2, ERR_TMO=3, and MSG_LEN_DEFAULT=4.
- Natural sub-module: rx_timeout_cntr, a loadable inactivity counter with clear and expiry pulse, reusable by the slave TX path.

Test Plan:
- Reset, then bytes MARKER_MASTER, FLAG_TIME_MARK, 00, 00 with 5-cycle gaps -> tm_rcvd high exactly 1 cycle after the 4th strobe; busy high from after the 1st strobe until the 4th; msg_err never asserted.
- Strobes on consecutive cycles: SR message immediately followed by DPR message -> sr_rcvd, then dpr_rcvd 4 cycles later; no bytes dropped.
- Noise bytes 00, 3C, then MARKER_MASTER, 7E (non-flag) -> noise ignored silently; msg_err with err_code=1 one cycle after the 7E strobe; state returns to IDLE.
- MARKER_MASTER, FLAG_DATA_PACKET_REQUEST, 00, 01:
  - with STRICT_PAD=1 -> msg_err, err_code=2;
  - with STRICT_PAD=0 -> dpr_rcvd.
- TIMEOUT_CYC=16: MARKER_MASTER then silence -> msg_err with err_code=3 exactly 15 cycles after entering FLAG. Repeat with a strobe landing on the expiry cycle -> no error raised.
- Assert rst_n low after marker+flag, release, then send a full TM message -> no pulse from the aborted message; tm_rcvd for the new message only.
